sprite_point_feeder: RTL

//  Scans a 1-bit sprite bitmap in row-major order and emits centred, signed fixed-point
//  (x,y) coordinates, one per set pixel, into the free-running CORDIC rotator.

---
 rtl/sprite_point_feeder.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/sprite_point_feeder.sv
// Scans a 1-bit sprite ROM in row-major order and feeds centred fixed-point (x,y) points to the
// CORDIC rotator, with a valid/last tag pipeline matched to the CORDIC latency.
module sprite_point_feeder #(
   parameter int unsigned SPR_W      = 48,
   parameter int unsigned SPR_H      = 48,
   parameter int unsigned CENTER     = 23,
   parameter int unsigned FRAC_SHIFT = 4,
   parameter int unsigned CORDIC_LAT = 19,
   parameter int unsigned ADDR_W     = 12
) (
   input  logic              CLOCK_50,
   input  logic              reset_n,
   input  logic              start,
   output logic [ADDR_W-1:0] rom_addr,
   output logic              rom_rd_en,
   input  logic              rom_data,
   output logic [11:0]       cordic_x,
   output logic [11:0]       cordic_y,
   output logic              pt_valid,
   output logic              res_valid,
   output logic              res_last,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] pt_count
);

   localparam int unsigned CntW = (CORDIC_LAT > 1) ? $clog2(CORDIC_LAT) : 1;

   typedef enum logic [1:0] {StIdle, StScan, StDrain, StDone} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d, col_q, col_d, row_q, row_d;
   logic                rd_en_q, rd_en_d, rd_last_q, rd_last_d;
   logic [ADDR_W-1:0]   dcol_q, dcol_d, drow_q, drow_d;
   logic                data_vld_q, data_vld_d, data_last_q, data_last_d;
   logic                flush_q, flush_d, tail_q, tail_d;
   logic                hold_vld_q, hold_vld_d;
   logic [11:0]         hold_x_q, hold_x_d, hold_y_q, hold_y_d;
   logic [11:0]         cx_q, cx_d, cy_q, cy_d;
   logic                pt_valid_q, pt_valid_d, pt_last_q, pt_last_d;
   logic [CORDIC_LAT-1:0] vpipe_q, vpipe_d, lpipe_q, lpipe_d;
   logic                busy_q, busy_d, done_q, done_d;
   logic [ADDR_W-1:0]   pt_count_q, pt_count_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [ADDR_W-1:0]   nxt_col, nxt_row;
   logic                nxt_last;

   // Two's-complement wrap at 12 bits gives the signed centred value directly.
   function automatic logic [11:0] centre(input logic [ADDR_W-1:0] p);
      logic [11:0] c;
      c = 12'(p) - 12'(CENTER);
      return c << FRAC_SHIFT;
   endfunction

   always_comb begin
      if (col_q == ADDR_W'(SPR_W - 1)) begin
         nxt_col = '0;
         nxt_row = row_q + 1'b1;
      end else begin
         nxt_col = col_q + 1'b1;
         nxt_row = row_q;
      end
      nxt_last = (nxt_row == ADDR_W'(SPR_H - 1)) && (nxt_col == ADDR_W'(SPR_W - 1));
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      col_d       = col_q;
      row_d       = row_q;
      rd_en_d     = rd_en_q;
      rd_last_d   = rd_last_q;
      dcol_d      = dcol_q;
      drow_d      = drow_q;
      hold_vld_d  = hold_vld_q;
      hold_x_d    = hold_x_q;
      hold_y_d    = hold_y_q;
      cx_d        = cx_q;
      cy_d        = cy_q;
      busy_d      = busy_q;
      pt_count_d  = pt_count_q;
      cnt_d       = cnt_q;
      pt_valid_d  = 1'b0;
      pt_last_d   = 1'b0;
      done_d      = 1'b0;
      data_vld_d  = rd_en_q;
      data_last_d = rd_en_q & rd_last_q;
      flush_d     = data_last_q;
      tail_d      = flush_q;
      vpipe_d     = CORDIC_LAT'({vpipe_q, pt_valid_q});
      lpipe_d     = CORDIC_LAT'({lpipe_q, pt_last_q});

      if (rd_en_q) begin
         dcol_d = col_q;
         drow_d = row_q;
      end

      // A captured pixel releases the previously held one; the final hold leaves on flush.
      if (data_vld_q && rom_data) begin
         if (hold_vld_q) begin
            pt_valid_d = 1'b1;
            cx_d       = hold_x_q;
            cy_d       = hold_y_q;
         end
         hold_vld_d = 1'b1;
         hold_x_d   = centre(dcol_q);
         hold_y_d   = centre(drow_q);
         pt_count_d = pt_count_q + 1'b1;
      end else if (flush_q && hold_vld_q) begin
         pt_valid_d = 1'b1;
         pt_last_d  = 1'b1;
         cx_d       = hold_x_q;
         cy_d       = hold_y_q;
         hold_vld_d = 1'b0;
      end

      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d    = StScan;
               busy_d     = 1'b1;
               pt_count_d = '0;
               addr_d     = '0;
               col_d      = '0;
               row_d      = '0;
               rd_en_d    = 1'b1;
               rd_last_d  = (SPR_W == 1) && (SPR_H == 1);
               hold_vld_d = 1'b0;
            end
         end
         StScan: begin
            if (rd_en_q) begin
               if (rd_last_q) begin
                  rd_en_d   = 1'b0;
                  rd_last_d = 1'b0;
               end else begin
                  addr_d    = addr_q + 1'b1;
                  col_d     = nxt_col;
                  row_d     = nxt_row;
                  rd_last_d = nxt_last;
               end
            end
            if (tail_q) begin
               state_d = StDrain;
               cnt_d   = '0;
            end
         end
         StDrain: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CntW'(CORDIC_LAT - 1)) begin
               state_d = StDone;
               done_d  = 1'b1;
               busy_d  = 1'b0;
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         addr_q      <= '0;
         col_q       <= '0;
         row_q       <= '0;
         rd_en_q     <= 1'b0;
         rd_last_q   <= 1'b0;
         dcol_q      <= '0;
         drow_q      <= '0;
         data_vld_q  <= 1'b0;
         data_last_q <= 1'b0;
         flush_q     <= 1'b0;
         tail_q      <= 1'b0;
         hold_vld_q  <= 1'b0;
         hold_x_q    <= '0;
         hold_y_q    <= '0;
         cx_q        <= '0;
         cy_q        <= '0;
         pt_valid_q  <= 1'b0;
         pt_last_q   <= 1'b0;
         vpipe_q     <= '0;
         lpipe_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pt_count_q  <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         col_q       <= col_d;
         row_q       <= row_d;
         rd_en_q     <= rd_en_d;
         rd_last_q   <= rd_last_d;
         dcol_q      <= dcol_d;
         drow_q      <= drow_d;
         data_vld_q  <= data_vld_d;
         data_last_q <= data_last_d;
         flush_q     <= flush_d;
         tail_q      <= tail_d;
         hold_vld_q  <= hold_vld_d;
         hold_x_q    <= hold_x_d;
         hold_y_q    <= hold_y_d;
         cx_q        <= cx_d;
         cy_q        <= cy_d;
         pt_valid_q  <= pt_valid_d;
         pt_last_q   <= pt_last_d;
         vpipe_q     <= vpipe_d;
         lpipe_q     <= lpipe_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         pt_count_q  <= pt_count_d;
         cnt_q       <= cnt_d;
      end
   end

   assign rom_addr  = addr_q;
   assign rom_rd_en = rd_en_q;
   assign cordic_x  = cx_q;
   assign cordic_y  = cy_q;
   assign pt_valid  = pt_valid_q;
   assign res_valid = vpipe_q[CORDIC_LAT-1];
   assign res_last  = lpipe_q[CORDIC_LAT-1];
   assign busy      = busy_q;
   assign done      = done_q;
   assign pt_count  = pt_count_q;

endmodule
